// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store queue between the execution stage and the
// data port. A circular buffer with write, issue and retire pointers turns
// queued memory ops into data-port requests. Load results are returned to the
// decoder-stage register write-back port.
// Optional feature: define LSU_QUEUE_ERR_CAPTURE_EN to add sticky capture of
// the first errored response address (err_valid_o / err_addr_o / err_clr_i).
module lsu_queue #(
    parameter int C_XLEN    = 32,
    parameter int C_DEPTH_X = 2
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    output logic              exs_full_o,
    input  logic              exs_lq_wr_i,
    input  logic              exs_sq_wr_i,
    input  logic [2:0]        exs_funct3_i,
    input  logic [4:0]        exs_regd_addr_i,
    input  logic [C_XLEN-1:0] exs_regs2_data_i,
    input  logic [C_XLEN-1:0] exs_addr_i,
    input  logic              dreqready_i,
    output logic              dreqvalid_o,
    output logic [1:0]        dreqhpl_o,
    output logic [C_XLEN-1:0] dreqaddr_o,
    output logic              dreqwr_o,
    output logic [3:0]        dreqbe_o,
    output logic [C_XLEN-1:0] dreqwdata_o,
    output logic              drspready_o,
    input  logic              drspvalid_i,
    input  logic              drsprerr_i,
    input  logic              drspwerr_i,
    input  logic [C_XLEN-1:0] drspdata_i,
`ifdef LSU_QUEUE_ERR_CAPTURE_EN
    output logic              err_valid_o,
    output logic [C_XLEN-1:0] err_addr_o,
    input  logic              err_clr_i,
`endif
    output logic              ids_reg_wr_o,
    output logic [4:0]        ids_reg_addr_o,
    output logic [C_XLEN-1:0] ids_reg_data_o
);

    localparam int DEPTH = 1 << C_DEPTH_X;

    typedef logic [C_DEPTH_X:0] ptr_t;

    typedef struct packed {
        logic              st;
        logic [2:0]        funct3;
        logic [4:0]        regd;
        logic [C_XLEN-1:0] data;
        logic [C_XLEN-1:0] addr;
    } entry_t;

    entry_t mem_q [DEPTH];

    ptr_t wr_q, wr_d, iss_q, iss_d, rsp_q, rsp_d;
    ptr_t count;
    logic [C_DEPTH_X-1:0] wr_idx, iss_idx, rsp_idx;
    logic enq, req_acc, rsp_acc;

    logic              ids_wr_q, ids_wr_d;
    logic [4:0]        ids_addr_q, ids_addr_d;
    logic [C_XLEN-1:0] ids_data_q, ids_data_d;
    logic [C_XLEN-1:0] ld_shift, ld_data;
    logic              sign_ext;

    assign wr_idx  = wr_q[C_DEPTH_X-1:0];
    assign iss_idx = iss_q[C_DEPTH_X-1:0];
    assign rsp_idx = rsp_q[C_DEPTH_X-1:0];

    // Occupancy never exceeds DEPTH, so its top bit alone flags a full queue.
    assign count       = wr_q - rsp_q;
    assign exs_full_o  = count[C_DEPTH_X];
    assign dreqvalid_o = (iss_q != wr_q);
    assign drspready_o = (rsp_q != iss_q);
    assign dreqhpl_o   = 2'b11;

    assign enq     = clk_en_i && (exs_lq_wr_i || exs_sq_wr_i) && !exs_full_o;
    assign req_acc = clk_en_i && dreqvalid_o && dreqready_i;
    assign rsp_acc = clk_en_i && drspvalid_i && drspready_o;

    // Next pointer values: each pointer steps by one on its own event.
    always_comb begin
        wr_d  = wr_q + ptr_t'(enq);
        iss_d = iss_q + ptr_t'(req_acc);
        rsp_d = rsp_q + ptr_t'(rsp_acc);
    end

    // Pointer registers; reset empties the queue.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_q  <= '0;
            iss_q <= '0;
            rsp_q <= '0;
        end else begin
            wr_q  <= wr_d;
            iss_q <= iss_d;
            rsp_q <= rsp_d;
        end
    end

    // Entry storage written at the write pointer on enqueue; both strobes high counts as a store.
    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_idx] <= '{st:     exs_sq_wr_i,
                               funct3: exs_funct3_i,
                               regd:   exs_regd_addr_i,
                               data:   exs_regs2_data_i,
                               addr:   exs_addr_i};
        end
    end

    // Request fields from the entry at the issue pointer, zero when nothing is pending.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dreqaddr_o  = '0;
        dreqwr_o    = 1'b0;
        dreqbe_o    = '0;
        dreqwdata_o = '0;
        if (dreqvalid_o) begin
            dreqaddr_o = {mem_q[iss_idx].addr[C_XLEN-1:2], 2'b00};
            dreqwr_o   = mem_q[iss_idx].st;
            case (mem_q[iss_idx].funct3[1:0])
                2'b00: begin
                    dreqbe_o    = 4'b0001 << mem_q[iss_idx].addr[1:0];
                    dreqwdata_o = {4{mem_q[iss_idx].data[7:0]}};
                end
                2'b01: begin
                    dreqbe_o    = 4'b0011 << {mem_q[iss_idx].addr[1], 1'b0};
                    dreqwdata_o = {2{mem_q[iss_idx].data[15:0]}};
                end
                default: begin
                    dreqbe_o    = 4'b1111;
                    dreqwdata_o = mem_q[iss_idx].data;
                end
            endcase
            if (!mem_q[iss_idx].st) begin
                dreqwdata_o = '0;
            end
        end
    end

    // Load result: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        ld_shift = drspdata_i >> {mem_q[rsp_idx].addr[1:0], 3'b000};
        sign_ext = ~mem_q[rsp_idx].funct3[2];
        case (mem_q[rsp_idx].funct3[1:0])
            2'b00:   ld_data = {{24{sign_ext & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_data = {{16{sign_ext & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Write-back decision: clean load responses with a non-zero destination only.
    always_comb begin
        ids_wr_d   = 1'b0;
        ids_addr_d = ids_addr_q;
        ids_data_d = ids_data_q;
        if (rsp_acc && !mem_q[rsp_idx].st && !drsprerr_i && (mem_q[rsp_idx].regd != 5'd0)) begin
            ids_wr_d   = 1'b1;
            ids_addr_d = mem_q[rsp_idx].regd;
            ids_data_d = ld_data;
        end
    end

    // Write-back port registers, one cycle after response acceptance.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            ids_wr_q   <= 1'b0;
            ids_addr_q <= '0;
            ids_data_q <= '0;
        end else if (clk_en_i) begin
            ids_wr_q   <= ids_wr_d;
            ids_addr_q <= ids_addr_d;
            ids_data_q <= ids_data_d;
        end
    end

    assign ids_reg_wr_o   = ids_wr_q;
    assign ids_reg_addr_o = ids_addr_q;
    assign ids_reg_data_o = ids_data_q;

`ifdef LSU_QUEUE_ERR_CAPTURE_EN
    logic              err_valid_q;
    logic [C_XLEN-1:0] err_addr_q;
    logic              err_hit;

    assign err_hit = rsp_acc && (mem_q[rsp_idx].st ? drspwerr_i : drsprerr_i);

    // Sticky first-error capture; a clear coinciding with a new error keeps the new one.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (clk_en_i) begin
            if (err_hit && (!err_valid_q || err_clr_i)) begin
                err_valid_q <= 1'b1;
                err_addr_q  <= mem_q[rsp_idx].addr;
            end else if (err_clr_i) begin
                err_valid_q <= 1'b0;
            end
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
`else
    logic unused_werr;
    assign unused_werr = drspwerr_i;
`endif

endmodule

// File: tb/tb_lsu_queue.sv
// tb_lsu_queue: directed scenarios plus randomized traffic for lsu_queue,
// checked every cycle against a queue-level behavioural model.
// Define LSU_QUEUE_ERR_CAPTURE_EN to also check the error-capture ports.
`timescale 1ns/1ps
module tb_lsu_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetb;
    logic        clk_en;
    logic        lq_wr, sq_wr;
    logic [2:0]  funct3;
    logic [4:0]  regd;
    logic [31:0] sdata, addr;
    logic        dreqready, drspvalid, rerr, werr, err_clr;
    logic [31:0] rdata;

    logic        exs_full_o, dreqvalid_o, dreqwr_o, drspready_o, ids_reg_wr_o;
    logic [1:0]  dreqhpl_o;
    logic [31:0] dreqaddr_o, dreqwdata_o, ids_reg_data_o;
    logic [3:0]  dreqbe_o;
    logic [4:0]  ids_reg_addr_o;
`ifdef LSU_QUEUE_ERR_CAPTURE_EN
    logic        err_valid_o;
    logic [31:0] err_addr_o;
`endif

    int checks = 0;
    int errors = 0;

    lsu_queue #(.C_XLEN(32), .C_DEPTH_X(2)) dut (
        .clk_i            (clk),
        .resetb_i         (resetb),
        .clk_en_i         (clk_en),
        .exs_full_o       (exs_full_o),
        .exs_lq_wr_i      (lq_wr),
        .exs_sq_wr_i      (sq_wr),
        .exs_funct3_i     (funct3),
        .exs_regd_addr_i  (regd),
        .exs_regs2_data_i (sdata),
        .exs_addr_i       (addr),
        .dreqready_i      (dreqready),
        .dreqvalid_o      (dreqvalid_o),
        .dreqhpl_o        (dreqhpl_o),
        .dreqaddr_o       (dreqaddr_o),
        .dreqwr_o         (dreqwr_o),
        .dreqbe_o         (dreqbe_o),
        .dreqwdata_o      (dreqwdata_o),
        .drspready_o      (drspready_o),
        .drspvalid_i      (drspvalid),
        .drsprerr_i       (rerr),
        .drspwerr_i       (werr),
        .drspdata_i       (rdata),
`ifdef LSU_QUEUE_ERR_CAPTURE_EN
        .err_valid_o      (err_valid_o),
        .err_addr_o       (err_addr_o),
        .err_clr_i        (err_clr),
`endif
        .ids_reg_wr_o     (ids_reg_wr_o),
        .ids_reg_addr_o   (ids_reg_addr_o),
        .ids_reg_data_o   (ids_reg_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit        st;
        bit [2:0]  f3;
        bit [4:0]  rd;
        bit [31:0] addr;
        bit [31:0] data;
    } op_t;

    op_t       pend[$];   // enqueued, not yet requested
    op_t       outs[$];   // requested, awaiting response
    bit        exp_wr;
    bit [4:0]  exp_rd;
    bit [31:0] exp_data;
    bit        exp_ev;
    bit [31:0] exp_ea;

    function automatic bit [3:0] model_be(bit [2:0] f3, bit [31:0] a);
        int sz = 1 << f3[1:0];
        int base = int'(a[1:0]);
        bit [3:0] b = '0;
        for (int i = 0; i < 4; i++) b[i] = (i >= base) && (i < base + sz);
        return b;
    endfunction

    function automatic bit [31:0] model_wdata(bit st, bit [2:0] f3, bit [31:0] d);
        int sz = 1 << f3[1:0];
        bit [31:0] w = '0;
        if (st) for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic bit [31:0] load_result(bit [2:0] f3, bit [31:0] a, bit [31:0] d);
        int sz = 1 << f3[1:0];
        int base = int'(a[1:0]);
        bit [31:0] v = '0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = d[8*(base + k) +: 8];
        if (!f3[2] && sz < 4 && v[8*sz - 1]) for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic model_reset();
        pend.delete();
        outs.delete();
        exp_wr   = 1'b0;
        exp_rd   = '0;
        exp_data = '0;
        exp_ev   = 1'b0;
        exp_ea   = '0;
    endtask

    task automatic model_step();
        op_t o;
        bit  full_pre, hit;
        full_pre = (pend.size() + outs.size()) == DEPTH;
        exp_wr = 1'b0;
        hit    = 1'b0;
        if (drspvalid && outs.size() > 0) begin
            o = outs.pop_front();
            if (!o.st && !rerr && o.rd != 5'd0) begin
                exp_wr   = 1'b1;
                exp_rd   = o.rd;
                exp_data = load_result(o.f3, o.addr, rdata);
            end
            hit = o.st ? werr : rerr;
            if (hit && (!exp_ev || err_clr)) exp_ea = o.addr;
        end
        if (hit && (!exp_ev || err_clr)) exp_ev = 1'b1;
        else if (err_clr)                exp_ev = 1'b0;
        if (pend.size() > 0 && dreqready) outs.push_back(pend.pop_front());
        if ((lq_wr || sq_wr) && !full_pre) begin
            o.st = sq_wr; o.f3 = funct3; o.rd = regd; o.addr = addr; o.data = sdata;
            pend.push_back(o);
        end
    endtask

    always @(posedge clk or negedge resetb) begin
        if (!resetb) model_reset();
        else if (clk_en) model_step();
    end

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        op_t o;
        check("full", 32'(exs_full_o), 32'((pend.size() + outs.size()) == DEPTH));
        check("hpl", 32'(dreqhpl_o), 32'd3);
        check("req_valid", 32'(dreqvalid_o), 32'(pend.size() > 0));
        if (pend.size() > 0) begin
            o = pend[0];
            check("req_addr", dreqaddr_o, o.addr & 32'hFFFF_FFFC);
            check("req_wr", 32'(dreqwr_o), 32'(o.st));
            check("req_be", 32'(dreqbe_o), 32'(model_be(o.f3, o.addr)));
            check("req_wdata", dreqwdata_o, model_wdata(o.st, o.f3, o.data));
        end
        check("rsp_ready", 32'(drspready_o), 32'(outs.size() > 0));
        check("reg_wr", 32'(ids_reg_wr_o), 32'(exp_wr));
        if (exp_wr) begin
            check("reg_addr", 32'(ids_reg_addr_o), 32'(exp_rd));
            check("reg_data", ids_reg_data_o, exp_data);
        end
`ifdef LSU_QUEUE_ERR_CAPTURE_EN
        check("err_valid", 32'(err_valid_o), 32'(exp_ev));
        if (exp_ev) check("err_addr", err_addr_o, exp_ea);
`endif
    endtask

    // Outputs are purely register-driven, so sampling at the falling edge is stable.
    always @(negedge clk) compare_outputs();

    always @(posedge clk) begin
        if (resetb) assert (!(lq_wr && sq_wr)) else $error("load and store enqueue strobes both high");
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_idle();
        lq_wr = 0; sq_wr = 0; funct3 = 0; regd = 0; sdata = 0; addr = 0;
        dreqready = 0; drspvalid = 0; rerr = 0; werr = 0; rdata = 0; err_clr = 0;
    endtask

    task automatic enq(input bit st, input bit [2:0] f3, input bit [4:0] rd,
                       input bit [31:0] a, input bit [31:0] d);
        lq_wr = !st; sq_wr = st; funct3 = f3; regd = rd; addr = a; sdata = d;
        cyc();
        lq_wr = 0; sq_wr = 0;
    endtask

    task automatic rsp(input bit [31:0] d, input bit re, input bit we);
        drspvalid = 1; rdata = d; rerr = re; werr = we;
        cyc();
        drspvalid = 0; rerr = 0; werr = 0;
    endtask

    task automatic random_inputs();
        bit [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bit [2:0] f3;
        int kind, sz;
        clk_en = ($urandom % 10) != 0;
        kind = $urandom % 3;
        f3 = (kind == 2) ? 3'($urandom % 3) : ld_f3[$urandom % 5];
        sz = 1 << f3[1:0];
        lq_wr = (kind == 1);
        sq_wr = (kind == 2);
        funct3 = f3;
        regd = 5'($urandom % 32);
        addr = $urandom & ~(32'(sz) - 32'd1);
        sdata = $urandom;
        dreqready = ($urandom % 4) != 0;
        drspvalid = $urandom % 2;
        rerr = ($urandom % 8) == 0;
        werr = ($urandom % 8) == 0;
        rdata = $urandom;
        err_clr = ($urandom % 16) == 0;
    endtask

    initial begin
        resetb = 0;
        clk_en = 1;
        set_idle();
        repeat (3) @(negedge clk);
        #1;
        check("rst_full", 32'(exs_full_o), 32'd0);
        check("rst_valid", 32'(dreqvalid_o), 32'd0);
        check("rst_hpl", 32'(dreqhpl_o), 32'd3);
        check("rst_addr", dreqaddr_o, 32'd0);
        check("rst_be", 32'(dreqbe_o), 32'd0);
        check("rst_rspready", 32'(drspready_o), 32'd0);
        check("rst_regwr", 32'(ids_reg_wr_o), 32'd0);
        check("rst_regdata", ids_reg_data_o, 32'd0);
        resetb = 1;
        cyc();

        // lw x5, 0x100
        dreqready = 1;
        enq(0, 3'b010, 5'd5, 32'h100, 32'd0);
        check("t1_valid", 32'(dreqvalid_o), 32'd1);
        check("t1_addr", dreqaddr_o, 32'h100);
        check("t1_be", 32'(dreqbe_o), 32'hF);
        check("t1_wr", 32'(dreqwr_o), 32'd0);
        cyc();
        check("t1_rspready", 32'(drspready_o), 32'd1);
        cyc();
        rsp(32'hDEADBEEF, 0, 0);
        check("t1_regwr", 32'(ids_reg_wr_o), 32'd1);
        check("t1_regaddr", 32'(ids_reg_addr_o), 32'd5);
        check("t1_regdata", ids_reg_data_o, 32'hDEADBEEF);
        cyc();
        check("t1_pulse", 32'(ids_reg_wr_o), 32'd0);

        // lb / lbu x3, 0x203
        enq(0, 3'b000, 5'd3, 32'h203, 32'd0);
        check("t2_be", 32'(dreqbe_o), 32'h8);
        check("t2_addr", dreqaddr_o, 32'h200);
        cyc();
        rsp(32'h80FFFFFF, 0, 0);
        check("t2_lb", ids_reg_data_o, 32'hFFFFFF80);
        enq(0, 3'b100, 5'd3, 32'h203, 32'd0);
        cyc();
        rsp(32'h80FFFFFF, 0, 0);
        check("t2_lbu", ids_reg_data_o, 32'h00000080);

        // sh 0x1234ABCD to 0x302
        enq(1, 3'b001, 5'd0, 32'h302, 32'h1234ABCD);
        check("t3_addr", dreqaddr_o, 32'h300);
        check("t3_be", 32'(dreqbe_o), 32'hC);
        check("t3_wdata", dreqwdata_o, 32'hABCDABCD);
        check("t3_wr", 32'(dreqwr_o), 32'd1);
        cyc();
        rsp(32'd0, 0, 0);
        check("t3_noreg", 32'(ids_reg_wr_o), 32'd0);

        // fill to depth with ready low, fifth enqueue ignored
        dreqready = 0;
        for (int i = 0; i < 4; i++) enq(0, 3'b010, 5'(i + 1), 32'h10 + 32'(4 * i), 32'd0);
        check("t4_full", 32'(exs_full_o), 32'd1);
        enq(0, 3'b010, 5'd9, 32'h80, 32'd0);
        check("t4_full_hold", 32'(exs_full_o), 32'd1);
        dreqready = 1;
        repeat (4) cyc();
        dreqready = 0;
        check("t4_all_issued", 32'(dreqvalid_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rsp(32'h1000 + 32'(i), 0, 0);
            check("t4_regaddr", 32'(ids_reg_addr_o), 32'(i + 1));
            check("t4_regdata", ids_reg_data_o, 32'h1000 + 32'(i));
            if (i == 0) check("t4_full_drop", 32'(exs_full_o), 32'd0);
        end
        cyc();
        check("t4_empty_rsp", 32'(drspready_o), 32'd0);
        check("t4_empty_req", 32'(dreqvalid_o), 32'd0);

        // lw x0, then lw x7 with read error
        dreqready = 1;
        enq(0, 3'b010, 5'd0, 32'h400, 32'd0);
        enq(0, 3'b010, 5'd7, 32'h404, 32'd0);
        cyc();
        rsp(32'h55, 0, 0);
        check("t5_x0", 32'(ids_reg_wr_o), 32'd0);
        rsp(32'h66, 1, 0);
        check("t5_rerr", 32'(ids_reg_wr_o), 32'd0);
`ifdef LSU_QUEUE_ERR_CAPTURE_EN
        check("t5_errv", 32'(err_valid_o), 32'd1);
        check("t5_erra", err_addr_o, 32'h404);
        err_clr = 1;
        cyc();
        err_clr = 0;
        check("t5_errclr", 32'(err_valid_o), 32'd0);
`endif

        // reset with two requests outstanding, then a stale response
        enq(0, 3'b010, 5'd1, 32'h500, 32'd0);
        enq(0, 3'b010, 5'd2, 32'h504, 32'd0);
        cyc();
        check("t6_outstanding", 32'(drspready_o), 32'd1);
        resetb = 0;
        cyc();
        resetb = 1;
        drspvalid = 1;
        rdata = 32'h12345678;
        cyc();
        check("t6_rspready", 32'(drspready_o), 32'd0);
        check("t6_noreg", 32'(ids_reg_wr_o), 32'd0);
        check("t6_full", 32'(exs_full_o), 32'd0);
        set_idle();

        // randomized traffic with a reset pulse midway
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (n == 1500) begin
                resetb = 0;
                cyc();
                resetb = 1;
            end
            random_inputs();
        end

        // drain
        set_idle();
        clk_en = 1;
        dreqready = 1;
        drspvalid = 1;
        repeat (20) cyc();
        check("drain_req", 32'(dreqvalid_o), 32'd0);
        check("drain_rsp", 32'(drspready_o), 32'd0);
        set_idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_queue.md
Name: lsu_queue

Overview:
- In-order load/store queue downstream of the execution stage; turns queued memory ops into data-port requests and returns load results to the decoder-stage register file write-back port.
- A circular buffer with three pointers: write, issue and retire. Entries between issue and write await request. Entries between retire and issue await response.
- Loads and stores share one queue, so program order holds across both.

Parameters:
C_XLEN, 32, data/address width (only 32 supported)
C_DEPTH_X, 2, queue depth base-2 exponent (depth = 2^C_DEPTH_X)

Ports:
clk_i  in  1  clock
resetb_i  in  1  reset, asynchronous, active-low
clk_en_i  in  1  clock enable; all state advances only when high
exs_full_o  out  1  queue full, ex stage must stall
exs_lq_wr_i  in  1  enqueue load
exs_sq_wr_i  in  1  enqueue store
exs_funct3_i  in  3  RV32I load/store funct3
exs_regd_addr_i  in  5  load destination register
exs_regs2_data_i  in  32  store data
exs_addr_i  in  32  effective address
dreqready_i  in  1  data request ready
dreqvalid_o  out  1  data request valid
dreqhpl_o  out  2  privilege level, constant 2'b11
dreqaddr_o  out  32  request address, word aligned
dreqwr_o  out  1  1 = store, 0 = load
dreqbe_o  out  4  byte enables
dreqwdata_o  out  32  lane-aligned store data
drspready_o  out  1  response ready
drspvalid_i  in  1  response valid
drsprerr_i  in  1  read error
drspwerr_i  in  1  write error
drspdata_i  in  32  read data
ids_reg_wr_o  out  1  register write strobe
ids_reg_addr_o  out  5  register address
ids_reg_data_o  out  32  register data

Behaviour:
- Reset values: all pointers 0. All outputs 0 except dreqhpl_o = 2'b11.
- Reset asserted mid-operation discards all entries. Responses arriving after reset are ignored because drspready_o is low.
- Pointers are C_DEPTH_X+1 bits wide.
- count = wr - rsp. exs_full_o = (count == depth). This is registered-state-derived; no combinational path from the ex inputs.
- Enqueue:
  - Occurs on clk_en_i & (lq_wr | sq_wr) & !full.
  - Enqueue while full is ignored.
  - lq_wr and sq_wr both high: treated as store (illegal; assertion in bench).
- Issue:
  - dreqvalid_o = (iss != wr). Request fields come from entry[iss].
  - Fields are held stable while valid & !ready.
  - Accepted on valid & ready & clk_en_i; iss increments.
  - Any number of requests may be outstanding, up to depth.
- Address and byte enables:
  - dreqaddr_o = {addr[31:2], 2'b00}.
  - Byte (funct3[1:0] = 00): be = 4'b0001 << addr[1:0]; wdata = byte replicated to 4 lanes.
  - Half (01): be = 4'b0011 << {addr[1], 1'b0}; wdata = half replicated to 2 lanes.
  - Word (10): be = 4'b1111.
  - Loads drive be from the same rules; wdata = 0.
  - Misaligned ops are never enqueued; the ex stage traps them.
- Response:
  - drspready_o = (rsp != iss). A response arriving in the same cycle its request is accepted is not taken.
  - Responses return in order. An accepted response retires entry[rsp]; rsp increments.
- Load write-back:
  - Load response without rerr: byte/half extracted per addr[1:0].
  - Extension: sign-extended for funct3 000/001, zero-extended for 100/101.
  - Result written via ids_reg_* one cycle after acceptance; ids_reg_wr_o is a single-cycle pulse.
  - No write when regd_addr = 0 or on rerr.
  - Store responses never write back. werr on a store is dropped, except as noted under Optional Feature.
- Simultaneous events: enqueue, issue and retire may all occur in one cycle. A full queue stalls enqueue even if retire occurs that cycle.
- clk_en_i low: no pointer moves, and no handshake completes on either port.

Optional Feature:
- Macro: LSU_QUEUE_ERR_CAPTURE_EN.
- Enabled: adds ports err_valid_o (out 1), err_addr_o (out 32) and err_clr_i (in 1).
  - On the first response with rerr (load) or werr (store), capture that entry's full byte address and set err_valid_o.
  - Both are sticky; later errors do not overwrite.
  - err_clr_i clears err_valid_o. If clear and a new error occur in the same cycle, the new error is captured.
  - Reset value: 0.
- Disabled: ports absent, errors only suppress write-back.

Test Plan:
1. lw x5, addr 0x100; ready = 1; response data 0xDEADBEEF after 2 cycles -> request addr 0x100, be = 1111, wr = 0; reg_wr pulse, addr 5, data 0xDEADBEEF, 1 cycle after response.
2. lb x3, addr 0x203, response 0x80FFFFFF -> be = 1000, data 0xFFFFFF80. Same op with lbu -> 0x00000080.
3. sh, data 0x1234ABCD, addr 0x302 -> addr 0x300, be = 1100, wdata 0xABCDABCD, wr = 1; no register write.
4. dreqready_i = 0, enqueue 4 loads (depth 4) -> exs_full_o = 1 after 4th; 5th enqueue ignored. Release ready and return responses -> 4 write-backs in order; full drops the cycle after the first retire.
5. lw x0, then lw x7 with rerr = 1 -> no register writes. With LSU_QUEUE_ERR_CAPTURE_EN: err_valid_o = 1, err_addr_o = the x7 load's address. err_clr_i -> 0.
6. Assert resetb_i low with 2 outstanding requests; deassert; drive stale drspvalid_i -> drspready_o = 0, no write-back, exs_full_o = 0.
